lock_code_checker: RTL and testbench
====================================

# lock_code_checker

Sequential keypad-code receiver for the lock system. It accepts one-digit-per-strobe keypad entries and compares the entered sequence against the stored combination using bitwise XOR equality. It drives the unlock, alarm and lockout outputs and enforces a retry limit. It is the receiving/checking end of the keypad digit stream and can optionally rewrite the stored combination.

## Interface
- DIGITS, 4: digits per combination.
- DEFAULT_CODE, 16'h1234: combination loaded at reset, 4 bits per digit, first digit in the MS nibble.
- MAX_TRIES, 3: consecutive failures that trigger lockout.
- OPEN_CYCLES, 500: cycles `unlocked` stays high.
- LOCKOUT_CYCLES, 1000: cycles of lockout.
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; `key_digit` is valid.
- key_digit  in  4  digit value 0–15.
- key_enter  in  1  one-cycle strobe; submit the entry.
- key_clear  in  1  one-cycle strobe; discard the partial entry.
- set_mode  in  1  one-cycle strobe; request a code change (OPEN only).
- unlocked  out  1  lock released.
- alarm  out  1  high during LOCKOUT.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- prog_active  out  1  high in PROGRAM.
- digit_cnt  out  3  digits captured in the current entry, saturates at DIGITS.
- tries  out  2  consecutive failures so far.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT, PROGRAM.
- Reset: state=IDLE; stored code=DEFAULT_CODE; entry register, digit_cnt, tries and timer=0. All outputs are 0.
- Input priority per cycle: key_clear > key_enter > key_valid.
- IDLE/ENTRY, key_valid:
  - The digit shifts into the entry register LSB-first-in, so earlier digits move toward the MSBs.
  - digit_cnt increments. IDLE moves to ENTRY.
  - A digit arriving when digit_cnt==DIGITS sets an internal overflow flag and is not stored.
- key_clear in ENTRY: entry, digit_cnt and overflow clear; state goes to IDLE. tries is unchanged.
- key_enter in IDLE/ENTRY goes to CHECK. CHECK lasts one cycle.
  - Match means all XOR bits of entry vs stored are zero AND digit_cnt==DIGITS AND no overflow.
  - Match: go to OPEN; tries=0; timer loads OPEN_CYCLES.
  - Otherwise: go to FAIL.
- FAIL lasts one cycle.
  - fail_pulse=1 and tries increments.
  - If the new tries==MAX_TRIES: go to LOCKOUT, timer loads LOCKOUT_CYCLES. Else go to IDLE.
  - Entry, digit_cnt and overflow clear on leaving CHECK, whatever the outcome.
- OPEN: unlocked=1. The timer decrements each cycle and the state returns to IDLE when it reaches 0. Key inputs are ignored except set_mode.
- LOCKOUT: alarm=1 and all key inputs are ignored. When the timer expires: tries=0, go to IDLE.
- PROGRAM (see Configuration):
  - Digits are captured exactly as in ENTRY.
  - key_enter with digit_cnt==DIGITS and no overflow writes the entry to the stored code, then goes to IDLE.
  - Any other key_enter leaves the code unchanged and goes to IDLE.
  - key_clear aborts to IDLE with the code unchanged.
- rst in any state, including mid-entry, OPEN, LOCKOUT or PROGRAM, returns to the full reset condition on the next edge. The stored code reverts to DEFAULT_CODE.

## Timing
- Each strobe is sampled on the rising edge. digit_cnt updates the cycle after key_valid.
- key_enter at edge N: CHECK is the state during cycle N+1.
  - Match: unlocked is high from edge N+2 for exactly OPEN_CYCLES cycles.
  - Mismatch: fail_pulse is high during cycle N+2.
  - Lockout: alarm is high from edge N+3 for LOCKOUT_CYCLES cycles.
- The tries output reflects its increment from edge N+3.
- Strobes arriving during CHECK/FAIL are dropped.
- Back-to-back key_valid on consecutive cycles are all accepted.

## Configuration
- LOCK_PROGRAM_EN defined:
  - set_mode in OPEN exits OPEN immediately, clears unlocked and the timer, and goes to PROGRAM.
  - prog_active=1 while in PROGRAM.
- LOCK_PROGRAM_EN undefined:
  - PROGRAM state and the code-write path are absent.
  - The stored code is the constant DEFAULT_CODE.
  - set_mode is ignored; prog_active is tied to 0.

## Test plan
- Correct code: digits 1,2,3,4 then enter -> unlocked=1 for 500 cycles starting 2 cycles after enter; tries=0.
- Wrong code: 1,2,3,5 then enter -> fail_pulse for 1 cycle, tries=1, unlocked stays 0.
- Three failures: wrong entries 3 times -> alarm=1 for 1000 cycles. Digits and enter during the alarm are ignored. Afterwards tries=0, and 1,2,3,4 then enter unlocks.
- Length faults:
  - 1,2,3 then enter -> failure.
  - 1,2,3,4,4 then enter -> failure (overflow).
  - key_clear after 1,2 followed by 1,2,3,4 then enter -> unlock.
- Program (LOCK_PROGRAM_EN):
  - Unlock, set_mode, 9,8,7,6, enter -> 1,2,3,4 then enter fails and 9,8,7,6 then enter unlocks.
  - rst -> 1,2,3,4 then enter unlocks again.
- Reset mid-OPEN: assert rst at cycle 100 of OPEN -> unlocked=0, digit_cnt=0, state IDLE on the next edge.

Source files
------------

// File: rtl/lock_code_checker.sv
// Keypad combination checker: digit capture, XOR compare, retry limit, lockout.
// Define LOCK_PROGRAM_EN to allow rewriting the stored code from the OPEN state.
module lock_code_checker #(
  parameter int unsigned          DIGITS         = 4,
  parameter logic [DIGITS*4-1:0]  DEFAULT_CODE   = 16'h1234,
  parameter int unsigned          MAX_TRIES      = 3,
  parameter int unsigned          OPEN_CYCLES    = 500,
  parameter int unsigned          LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       set_mode,
  output logic       unlocked,
  output logic       alarm,
  output logic       fail_pulse,
  output logic       prog_active,
  output logic [2:0] digit_cnt,
  output logic [1:0] tries
);

  localparam int unsigned EW   = DIGITS * 4;
  localparam int unsigned TMAX =
    (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT,
    S_PROGRAM
  } state_t;

  state_t          state_q;
  logic [EW-1:0]   entry_q;
  logic [2:0]      cnt_q;
  logic            ovf_q;
  logic [1:0]      tries_q;
  logic [TW-1:0]   timer_q;
  logic            unlocked_q;
  logic            alarm_q;
  logic            fail_q;

  logic [EW-1:0]   entry_d;
  logic [2:0]      cnt_d;
  logic [1:0]      tries_d;
  logic [TW-1:0]   timer_d;
  logic            full_w;
  logic            last_w;
  logic            match_w;
  logic [EW-1:0]   code_w;

`ifdef LOCK_PROGRAM_EN
  logic [EW-1:0]   code_q;
  logic            prog_q;
  assign code_w      = code_q;
  assign prog_active = prog_q;
`else
  logic            unused_set_mode;
  assign code_w          = DEFAULT_CODE;
  assign prog_active     = 1'b0;
  assign unused_set_mode = set_mode;
`endif

  // Newest digit enters at the LSB nibble; earlier digits move up.
  assign entry_d = {entry_q[EW-5:0], key_digit};
  assign cnt_d   = cnt_q + 3'd1;
  assign tries_d = tries_q + 2'd1;
  assign timer_d = timer_q - TW'(1);
  assign full_w  = (cnt_q == 3'(DIGITS));
  assign last_w  = (timer_q == TW'(1));
  assign match_w = ((entry_q ^ code_w) == '0) && full_w && !ovf_q;

  assign unlocked   = unlocked_q;
  assign alarm      = alarm_q;
  assign fail_pulse = fail_q;
  assign digit_cnt  = cnt_q;
  assign tries      = tries_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      tries_q    <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      fail_q     <= 1'b0;
`ifdef LOCK_PROGRAM_EN
      code_q     <= DEFAULT_CODE;
      prog_q     <= 1'b0;
`endif
    end else begin
      fail_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_ENTRY: begin
          if (key_clear) begin
            entry_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (key_enter) begin
            state_q <= S_CHECK;
          end else if (key_valid) begin
            state_q <= S_ENTRY;
            if (full_w) begin
              ovf_q <= 1'b1;
            end else begin
              entry_q <= entry_d;
              cnt_q   <= cnt_d;
            end
          end
        end
        S_CHECK: begin
          entry_q <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          if (match_w) begin
            state_q    <= S_OPEN;
            tries_q    <= '0;
            timer_q    <= TW'(OPEN_CYCLES);
            unlocked_q <= 1'b1;
          end else begin
            state_q <= S_FAIL;
            fail_q  <= 1'b1;
          end
        end
        S_FAIL: begin
          tries_q <= tries_d;
          if (tries_d == 2'(MAX_TRIES)) begin
            state_q <= S_LOCKOUT;
            timer_q <= TW'(LOCKOUT_CYCLES);
            alarm_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_OPEN: begin
`ifdef LOCK_PROGRAM_EN
          if (set_mode) begin
            state_q    <= S_PROGRAM;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            prog_q     <= 1'b1;
          end else
`endif
          if (last_w) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_LOCKOUT: begin
          if (last_w) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            tries_q <= '0;
            alarm_q <= 1'b0;
          end else begin
            timer_q <= timer_d;
          end
        end
`ifdef LOCK_PROGRAM_EN
        S_PROGRAM: begin
          if (key_clear || key_enter) begin
            if (!key_clear && full_w && !ovf_q) begin
              code_q <= entry_q;
            end
            entry_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            prog_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (key_valid) begin
            if (full_w) begin
              ovf_q <= 1'b1;
            end else begin
              entry_q <= entry_d;
              cnt_q   <= cnt_d;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_code_checker.sv
// Self-checking bench for lock_code_checker: directed key sequences,
// a per-cycle reference model, and hand-computed spot checks.
module tb_lock_code_checker;

  localparam int ND    = 4;
  localparam int OPENC = 500;
  localparam int LOCKC = 1000;
  localparam int MAXT  = 3;
`ifdef LOCK_PROGRAM_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic       key_clear;
  logic       set_mode;
  logic       unlocked;
  logic       alarm;
  logic       fail_pulse;
  logic       prog_active;
  logic [2:0] digit_cnt;
  logic [1:0] tries;

  always #5 clk = ~clk;

  lock_code_checker dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .set_mode    (set_mode),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .fail_pulse  (fail_pulse),
    .prog_active (prog_active),
    .digit_cnt   (digit_cnt),
    .tries       (tries)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: digit list, remaining-cycle counters, pending verdicts.
  int          q[$];
  int          ndig;
  int          open_left;
  int          lock_left;
  int          tries_m;
  bit          in_check;
  bit          in_fail;
  bit          prog_m;
  logic [15:0] code_m;
  bit          live = 1'b0;

  function automatic bit code_ok();
    logic [15:0] v;
    v = '0;
    foreach (q[i]) v = (v << 4) | 16'(q[i]);
    return (ndig == ND) && (v == code_m);
  endfunction

  task automatic clear_digits();
    q.delete();
    ndig = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      clear_digits();
      open_left = 0; lock_left = 0; tries_m = 0;
      in_check = 0; in_fail = 0; prog_m = 0;
      code_m = 16'h1234;
      live = 1'b1;
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) tries_m = 0;
    end else if (open_left > 0) begin
      if (PROG && set_mode) begin
        open_left = 0;
        prog_m = 1;
      end else open_left--;
    end else if (in_check) begin
      in_check = 0;
      if (code_ok()) begin
        open_left = OPENC;
        tries_m = 0;
      end else in_fail = 1;
      clear_digits();
    end else if (in_fail) begin
      in_fail = 0;
      tries_m++;
      if (tries_m == MAXT) lock_left = LOCKC;
    end else if (key_clear) begin
      clear_digits();
      prog_m = 0;
    end else if (key_enter) begin
      if (prog_m) begin
        if (ndig == ND) begin
          code_m = '0;
          foreach (q[i]) code_m = (code_m << 4) | 16'(q[i]);
        end
        prog_m = 0;
        clear_digits();
      end else in_check = 1;
    end else if (key_valid) begin
      ndig++;
      if (ndig <= ND) q.push_back(int'(key_digit));
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (live) begin
      chk("m_unlocked", int'(unlocked), int'(open_left > 0));
      chk("m_alarm", int'(alarm), int'(lock_left > 0));
      chk("m_fail_pulse", int'(fail_pulse), int'(in_fail));
      chk("m_prog_active", int'(prog_active), int'(prog_m));
      chk("m_digit_cnt", int'(digit_cnt), (ndig > ND) ? ND : ndig);
      chk("m_tries", int'(tries), tries_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_enter();
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
  endtask

  task automatic do_clear();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  task automatic do_set();
    set_mode = 1'b1;
    tick();
    set_mode = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < ND; i++) begin
      press(int'(v[15:12]));
      v = v << 4;
    end
  endtask

  // Counts consecutive cycles with unlocked high, bounded.
  task automatic wait_open(output int n);
    n = 0;
    while (unlocked && n < OPENC + 100) begin
      n++;
      tick();
    end
  endtask

  task automatic fail_attempt();
    enter_code(16'h1235);
    do_enter();
    tick();
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    key_valid = 1'b0; key_digit = '0; key_enter = 1'b0;
    key_clear = 1'b0; set_mode = 1'b0;
    repeat (3) tick();
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_digit_cnt", int'(digit_cnt), 0);
    chk("rst_tries", int'(tries), 0);
    rst = 1'b0;
    tick();

    // Correct code
    enter_code(16'h1234);
    chk("cnt_four", int'(digit_cnt), 4);
    do_enter();
    chk("check_cycle_locked", int'(unlocked), 0);
    tick();
    chk("unlock_edge", int'(unlocked), 1);
    wait_open(n);
    chk("open_len", n, 500);
    chk("tries_after_ok", int'(tries), 0);

    // Wrong code
    enter_code(16'h1235);
    do_enter();
    tick();
    chk("fail_pulse_hi", int'(fail_pulse), 1);
    chk("tries_before_inc", int'(tries), 0);
    tick();
    chk("fail_pulse_lo", int'(fail_pulse), 0);
    chk("tries_one", int'(tries), 1);
    chk("wrong_locked", int'(unlocked), 0);

    // Too short
    press(1); press(2); press(3);
    do_enter();
    tick();
    chk("short_fail", int'(fail_pulse), 1);
    tick();
    chk("tries_two", int'(tries), 2);

    // Clear then correct
    press(1); press(2);
    do_clear();
    chk("clear_cnt", int'(digit_cnt), 0);
    chk("clear_tries", int'(tries), 2);
    enter_code(16'h1234);
    do_enter();
    tick();
    chk("clear_unlock", int'(unlocked), 1);
    wait_open(n);
    chk("tries_reset_ok", int'(tries), 0);

    // Overflow
    enter_code(16'h1234);
    press(4);
    chk("cnt_saturate", int'(digit_cnt), 4);
    do_enter();
    tick();
    chk("ovf_fail", int'(fail_pulse), 1);
    tick();
    chk("ovf_tries", int'(tries), 1);

    // Two more failures -> lockout, keys ignored meanwhile
    fail_attempt();
    fail_attempt();
    chk("lock_alarm", int'(alarm), 1);
    chk("lock_tries", int'(tries), 3);
    n = 0;
    while (alarm && n < LOCKC + 100) begin
      key_valid = (n < 4);
      key_digit = 4'(n + 1);
      key_enter = (n == 4);
      n++;
      tick();
    end
    key_valid = 1'b0;
    key_enter = 1'b0;
    chk("lock_len", n, 1000);
    chk("lock_tries_clr", int'(tries), 0);
    chk("lock_cnt_clr", int'(digit_cnt), 0);
    chk("lock_no_unlock", int'(unlocked), 0);
    enter_code(16'h1234);
    do_enter();
    tick();
    chk("post_lock_unlock", int'(unlocked), 1);

`ifndef LOCK_PROGRAM_EN
    repeat (49) tick();
    do_set();
    chk("set_ignored_prog", int'(prog_active), 0);
    chk("set_ignored_open", int'(unlocked), 1);
    repeat (49) tick();
`else
    repeat (99) tick();
`endif
    // Reset at cycle 100 of OPEN
    rst = 1'b1;
    tick();
    chk("midopen_unlocked", int'(unlocked), 0);
    chk("midopen_cnt", int'(digit_cnt), 0);
    rst = 1'b0;
    tick();

`ifdef LOCK_PROGRAM_EN
    enter_code(16'h1234);
    do_enter();
    tick();
    tick();
    do_set();
    chk("prog_active", int'(prog_active), 1);
    chk("prog_locked", int'(unlocked), 0);
    enter_code(16'h9876);
    do_enter();
    chk("prog_done", int'(prog_active), 0);
    enter_code(16'h1234);
    do_enter();
    tick();
    chk("old_code_fails", int'(fail_pulse), 1);
    tick();
    enter_code(16'h9876);
    do_enter();
    tick();
    chk("new_code_unlocks", int'(unlocked), 1);
    wait_open(n);
    chk("new_open_len", n, 500);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    enter_code(16'h1234);
    do_enter();
    tick();
    chk("default_after_rst", int'(unlocked), 1);
    wait_open(n);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
